// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store initiator: access sizes,
// FSM state codes and big-endian lane selection.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef logic [1:0] mau_state_t;

    localparam mau_state_t ST_IDLE = 2'd0;
    localparam mau_state_t ST_RD   = 2'd1;
    localparam mau_state_t ST_WR   = 2'd2;
    localparam mau_state_t ST_RESP = 2'd3;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Big-endian: offset 0 is the most significant lane, so the shift shrinks as offset grows.
    function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic [1:0] size);
        logic [4:0] shift;
        case (size)
            SZ_BYTE: shift = {~offset, 3'b000};
            SZ_HALF: shift = {~offset[1], 4'b0000};
            default: shift = 5'd0;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends a sub-word lane for loads
// and merges a sub-word into a read word for read-modify-write stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  shift_s;
    logic [15:0] lane_s;
    logic [31:0] lane_mask_s;

    assign shift_s = lane_shift(offset, size);
    assign lane_s  = 16'(word >> shift_s);

    // Load path: right-justify the selected lane, then sign- or zero-extend.
    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: begin
                if (sign_ext) begin
                    load_data = {{24{lane_s[7]}}, lane_s[7:0]};
                end else begin
                    load_data = {24'h00_0000, lane_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (sign_ext) begin
                    load_data = {{16{lane_s[15]}}, lane_s};
                end else begin
                    load_data = {16'h0000, lane_s};
                end
            end
            default: load_data = word;
        endcase
    end

    // Store path: replace only the addressed lane; a full word passes wdata straight through.
    always_comb begin
        lane_mask_s = HALF_MASK;
        store_word  = wdata;
        case (size)
            SZ_BYTE: begin
                lane_mask_s = BYTE_MASK;
                store_word  = (word & ~(lane_mask_s << shift_s)) | ((wdata & lane_mask_s) << shift_s);
            end
            SZ_HALF: begin
                lane_mask_s = HALF_MASK;
                store_word  = (word & ~(lane_mask_s << shift_s)) | ((wdata & lane_mask_s) << shift_s);
            end
            default: begin
                lane_mask_s = HALF_MASK;
                store_word  = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a word-addressed data memory port;
// one request in flight, registered memory strobes, faults short-circuit to RESP.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 128,
    parameter int READ_WAIT = 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_readData
);

    localparam int          CNT_W       = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    mau_state_t        state_r, state_nxt_s;
    logic              ready_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [1:0]        offset_r, size_r;
    logic              signed_r, write_r;
    logic [31:0]       wdata_r;
    logic              resp_valid_r, resp_fault_r;
    logic [31:0]       resp_rdata_r;
    logic [31:0]       mem_address_r, mem_writedata_r;
    logic              mem_write_r, mem_read_r;

    logic              accept_s, fault_s;
    logic [31:0]       word_idx_s;
    logic [31:0]       load_data_s, store_word_s;

    assign accept_s   = req_valid && ready_r;
    assign word_idx_s = 32'(req_addr[ADDR_W-1:2]);

    // Fault classification of the offered request; only meaningful on acceptance.
    always_comb begin
        fault_s = 1'b0;
        case (req_size)
            SZ_BYTE: fault_s = 1'b0;
            SZ_HALF: fault_s = req_addr[0];
            SZ_WORD: fault_s = (req_addr[1:0] != 2'b00);
            default: fault_s = 1'b1;
        endcase
        if (word_idx_s >= MEM_WORDS_U) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
    end

    // Next-state: only word stores skip the read; sub-word stores read first for the merge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (fault_s) begin
                    state_nxt_s = ST_RESP;
                end else if (req_write && (req_size == SZ_WORD)) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD: begin
                if (rd_cnt_r != {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RD;
                end else if (write_r) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    mem_lane_align u_lane_align (
        .word       (mem_readData),
        .offset     (offset_r),
        .size       (size_r),
        .sign_ext   (signed_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // State, handshake and strobes are decoded from the next state so the outputs stay registered.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ready_r     <= (state_nxt_s == ST_IDLE);
            mem_read_r  <= (state_nxt_s == ST_RD);
            mem_write_r <= (state_nxt_s == ST_WR);
        end
    end

    // Request capture and read-wait countdown.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            offset_r      <= 2'b00;
            size_r        <= SZ_BYTE;
            signed_r      <= 1'b0;
            write_r       <= 1'b0;
            wdata_r       <= 32'h0000_0000;
            mem_address_r <= 32'h0000_0000;
            rd_cnt_r      <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            offset_r      <= req_addr[1:0];
            size_r        <= req_size;
            signed_r      <= req_signed;
            write_r       <= req_write;
            wdata_r       <= req_wdata;
            mem_address_r <= word_idx_s;
            rd_cnt_r      <= RD_LAST;
        end else if ((state_r == ST_RD) && (rd_cnt_r != {CNT_W{1'b0}})) begin
            rd_cnt_r      <= rd_cnt_r - CNT_W'(1);
        end else begin
            rd_cnt_r      <= rd_cnt_r;
        end
    end

    // Write data: raw word for word stores, merged word captured on the last read edge otherwise.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            mem_writedata_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_WR)) begin
            mem_writedata_r <= req_wdata;
        end else if ((state_r == ST_RD) && (state_nxt_s == ST_WR)) begin
            mem_writedata_r <= store_word_s;
        end else begin
            mem_writedata_r <= mem_writedata_r;
        end
    end

    // Response pulse; data and fault are zero outside the RESP cycle.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else if (state_nxt_s == ST_RESP) begin
            resp_valid_r <= 1'b1;
            resp_fault_r <= (state_r == ST_IDLE);
            if ((state_r == ST_RD) && !write_r) begin
                resp_rdata_r <= load_data_s;
            end else begin
                resp_rdata_r <= 32'h0000_0000;
            end
        end else begin
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end
    end

    assign req_ready     = ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_fault    = resp_fault_r;
    assign resp_rdata    = resp_rdata_r;
    assign mem_address   = mem_address_r;
    assign mem_writeData = mem_writedata_r;
    assign mem_memWrite  = mem_write_r;
    assign mem_memRead   = mem_read_r;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the multi-cycle pipeline's MEM stage: accepts one byte/halfword/word request at a time from the datapath and drives the word-addressed data memory port (address, writeData, memWrite, memRead, readData). It translates byte addresses to word indices, extracts and sign-extends sub-word loads, and performs read-modify-write for sub-word stores. It also flags misaligned and out-of-range accesses without touching memory.

## Interface
- ADDR_W, 32: byte-address width.
- MEM_WORDS, 128: memory depth in 32-bit words; valid word indices are 0..MEM_WORDS-1.
- READ_WAIT, 1: cycles memRead is held before readData is captured; must be ≥1.

Ports:
- clock_in  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on a posedge with req_valid&&req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; access was not performed.
- mem_address  out  32  word index = req_addr >> 2.
- mem_writeData  out  32  word to write.
- mem_memWrite  out  1  write strobe; memory commits on the negedge inside the strobe cycle.
- mem_memRead  out  1  read enable.
- mem_readData  in  32  combinational read data from memory.

## Operation
- States: IDLE, RD, WR, RESP. req_ready = (state == IDLE).
- Acceptance latches addr, size, signed, write, and wdata. Fault check is performed at acceptance:
  - size 3;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - word index ≥ MEM_WORDS.
- Transitions:
  - Fault: IDLE→RESP.
  - Word load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP.
  - Sub-word store: IDLE→RD→WR→RESP.
  - RESP→IDLE always.
- Byte order is big-endian. Byte offset 0 maps to bits [31:24], offset 3 to [7:0]. Half offset 0 maps to [31:16].
- Loads: the selected lane is right-justified, then sign-extended if req_signed, else zero-extended.
- Sub-word store: the captured word has its lane replaced by wdata[7:0] or wdata[15:0]; other lanes are unchanged.
- mem_address, mem_writeData, mem_memRead, and mem_memWrite are registered (glitch-free). mem_memRead=1 only in RD, mem_memWrite=1 only in WR.

## Timing
- Reset values:
  - state IDLE, req_ready 1;
  - resp_valid 0, resp_rdata 0, resp_fault 0;
  - mem_address 0, mem_writeData 0, mem_memWrite 0, mem_memRead 0.
- Acceptance edge = E0.
- RD lasts exactly READ_WAIT cycles. mem_readData is captured at the last RD edge.
- Response cycle (resp_valid=1), counted after E0:
  - fault: cycle 1;
  - word store: cycle 2;
  - word load: cycle 1+READ_WAIT;
  - sub-word load: cycle 1+READ_WAIT;
  - sub-word store: cycle 2+READ_WAIT.
- resp_rdata and resp_fault are valid only while resp_valid=1 and return to 0 afterwards.
- A new request is accepted at the earliest on the edge ending the cycle after RESP, i.e. in IDLE. Requests offered during busy states are ignored, not queued.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously). mem_memWrite drops within the cycle; no resp_valid is issued for the aborted request.
- Width rule: mem_address = {2'b00, req_addr[ADDR_W-1:2]} zero-extended to 32 bits.

## Structure
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the lane-select helper constants.
- Sub-module mem_lane_align (combinational):
  - load path: extract/extend a lane from a word given offset, size, and signed;
  - store path: insert a lane into a word.
- The FSM, latches, and fault check live in mem_access_unit.

## Test plan
- Word load at req_addr 0x10, memory word 4 = 0x80017F02:
  - cycle 1: mem_memRead=1, mem_address=4;
  - cycle 2: resp_valid=1, resp_rdata=0x80017F02, resp_fault=0.
- Byte loads on the same word:
  - signed load, addr 0x10 → 0xFFFFFF80;
  - unsigned load, addr 0x13 → 0x00000002;
  - signed half load, addr 0x12 → 0x00007F02.
- Byte store of 0xAB to addr 0x11 on word 0x80017F02:
  - RD one cycle, then WR with mem_writeData=0x80AB7F02 and mem_memWrite=1 for exactly one cycle;
  - resp_valid at cycle 3;
  - a following word load returns 0x80AB7F02.
- Faults, each giving resp_valid=resp_fault=1 at cycle 1 with no memRead/memWrite:
  - half load at 0x11;
  - word load at 0x200 (index 128);
  - req_size=3.
- Reset asserted mid-cycle during WR of a word store:
  - mem_memWrite falls before the next edge;
  - no resp_valid;
  - req_ready=1 after release.
- READ_WAIT=3, back-to-back word loads with req_valid held high:
  - mem_memRead held 3 cycles, resp_valid at cycle 4;
  - second request accepted at the edge ending cycle 5, with no request lost or duplicated.
